// File: rtl/keypad_operand_entry_pkg.sv
// Shared calc definitions: key codes, scanner state encoding and the digit decode.
package keypad_operand_entry_pkg;

  localparam logic [3:0] KEY_A    = 4'h3;
  localparam logic [3:0] KEY_B    = 4'h7;
  localparam logic [3:0] KEY_C    = 4'hB;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_D    = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } scan_state_t;

  // Returns {is_digit, bcd_digit} for a key code (row*4+col).
  function automatic logic [4:0] key_digit(input logic [3:0] code);
    logic [4:0] res;
    res = 5'b0_0000;
    case (code)
      4'h0: res = 5'b1_0001;
      4'h1: res = 5'b1_0010;
      4'h2: res = 5'b1_0011;
      4'h4: res = 5'b1_0100;
      4'h5: res = 5'b1_0101;
      4'h6: res = 5'b1_0110;
      4'h8: res = 5'b1_0111;
      4'h9: res = 5'b1_1000;
      4'hA: res = 5'b1_1001;
      4'hD: res = 5'b1_0000;
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_operand_entry_scanner.sv
// 4x4 keypad scanner: row synchronizer, one-hot-low column drive and debounce FSM.
//   state       | meaning
//   ST_SCAN     | drive columns in turn, dwell SCAN_DIV cycles each, look for a low row
//   ST_DEBOUNCE | column held, latched row must stay low DEBOUNCE_CNT cycles
//   ST_HOLD     | key accepted, wait for all rows high (no auto-repeat)
//   ST_RELEASE  | all rows must stay high DEBOUNCE_CNT cycles before rescanning
module keypad_scanner
  import keypad_operand_entry_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       accept,
  output logic [3:0] accept_code,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(MAXC + 1);

  scan_state_t    state, state_nxt;
  logic [3:0]     row_meta, row_s;
  logic [1:0]     col_idx, col_idx_nxt;
  logic [1:0]     row_idx, row_idx_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [3:0]     key_code_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta  <= 4'hF;
      row_s     <= 4'hF;
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      row_meta  <= row;
      row_s     <= row_meta;
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      row_idx   <= row_idx_nxt;
      cnt       <= cnt_nxt;
      key_valid <= accept;
      key_code  <= key_code_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_idx_nxt  = col_idx;
    row_idx_nxt  = row_idx;
    cnt_nxt      = cnt + CW'(1);
    accept       = 1'b0;
    accept_code  = {row_idx, col_idx};
    key_code_nxt = key_code;
    case (state)
      ST_SCAN: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          cnt_nxt = '0;
          if (row_s != 4'hF) begin
            state_nxt = ST_DEBOUNCE;
            // Lowest row index wins when several keys share the column.
            if (!row_s[0])      row_idx_nxt = 2'd0;
            else if (!row_s[1]) row_idx_nxt = 2'd1;
            else if (!row_s[2]) row_idx_nxt = 2'd2;
            else                row_idx_nxt = 2'd3;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (row_s[row_idx]) begin
          state_nxt   = ST_SCAN;
          col_idx_nxt = col_idx + 2'd1;
          cnt_nxt     = '0;
        end else if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
          state_nxt    = ST_HOLD;
          cnt_nxt      = '0;
          accept       = 1'b1;
          key_code_nxt = {row_idx, col_idx};
        end
      end
      ST_HOLD: begin
        cnt_nxt = '0;
        if (row_s == 4'hF) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (row_s != 4'hF) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
          state_nxt   = ST_SCAN;
          col_idx_nxt = col_idx + 2'd1;
          cnt_nxt     = '0;
        end
      end
      default: begin
        state_nxt = ST_SCAN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign col = ~(4'b0001 << col_idx);

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: turns accepted keys into edits of two 4-digit BCD operands.
module keypad_operand_entry
  import keypad_operand_entry_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] operandA,
  output logic [31:0] operandB,
  output logic        SW,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  logic        accept;
  logic [3:0]  accept_code;
  logic [15:0] opa, opb, opa_nxt, opb_nxt, cur, edit;
  logic        sw, sw_nxt;
  logic [4:0]  dec;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_scanner (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .accept      (accept),
    .accept_code (accept_code),
    .key_valid   (key_valid),
    .key_code    (key_code)
  );

  // Edits land on the same edge that raises key_valid, driven by the scanner's accept strobe.
  always_comb begin
    opa_nxt = opa;
    opb_nxt = opb;
    sw_nxt  = sw;
    dec     = key_digit(accept_code);
    cur     = sw ? opb : opa;
    edit    = cur;
    if (accept) begin
      if (dec[4]) begin
        edit = {cur[11:0], dec[3:0]};
      end else begin
        case (accept_code)
          KEY_A:    sw_nxt = 1'b0;
          KEY_B:    sw_nxt = 1'b1;
          KEY_C:    edit = 16'h0000;
          KEY_D:    edit = {4'h0, cur[15:4]};
          KEY_STAR: begin
            opa_nxt = 16'h0000;
            opb_nxt = 16'h0000;
            sw_nxt  = 1'b0;
          end
          KEY_HASH: begin
            opa_nxt = opb;
            opb_nxt = opa;
          end
          default: ;
        endcase
      end
      if (dec[4] || accept_code == KEY_C || accept_code == KEY_D) begin
        if (sw) opb_nxt = edit;
        else    opa_nxt = edit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= 16'h0000;
      opb <= 16'h0000;
      sw  <= 1'b0;
    end else begin
      opa <= opa_nxt;
      opb <= opb_nxt;
      sw  <= sw_nxt;
    end
  end

  assign operandA = {16'h0000, opa};
  assign operandB = {16'h0000, opb};
  assign SW       = sw;

endmodule
